// File: rtl/writeback_stage.sv
// Writeback stage of the RV32I pipeline: selects ALU / load / link value and drives the regfile write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic [4:0]      inRd,
    input  logic            inRegWrite,
    input  logic [1:0]      inWbSel,
    input  logic [2:0]      inFunct3,
    input  logic [XLEN-1:0] inAluResult,
    input  logic [XLEN-1:0] inPcPlus4,
    input  logic            memRspValid,
    input  logic [XLEN-1:0] memRspData,
    output logic            regWriteEnable,
    output logic [4:0]      regWriteAddr,
    output logic [XLEN-1:0] regWriteData,
    output logic            fwdValid,
    output logic [4:0]      fwdRd,
    output logic [XLEN-1:0] fwdData,
    output logic            loadPending,
    output logic            loadMisaligned,
    output logic [63:0]     instret
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_WAIT_MEM = 2'd2
    } state_t;

    state_t          r_state;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic [XLEN-1:0] r_data;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic            r_misaligned;

    logic            w_accept;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic            w_load_misaligned;
    logic            w_drop;
    state_t          w_state_next;

    assign w_accept = inValid && (r_state != S_WAIT_MEM);

    // Load alignment and extension use the address bits captured at accept time.
    always_comb begin
        w_byte            = memRspData[{r_addr_lo, 3'b000} +: 8];
        w_half            = r_addr_lo[1] ? memRspData[31:16] : memRspData[15:0];
        w_load_data       = memRspData;
        w_load_misaligned = (r_addr_lo != 2'b00);
        case (r_funct3)
            3'b000: begin
                w_load_data       = {{24{w_byte[7]}}, w_byte};
                w_load_misaligned = 1'b0;
            end
            3'b100: begin
                w_load_data       = {24'h0, w_byte};
                w_load_misaligned = 1'b0;
            end
            3'b001: begin
                w_load_data       = {{16{w_half[15]}}, w_half};
                w_load_misaligned = r_addr_lo[0];
            end
            3'b101: begin
                w_load_data       = {16'h0, w_half};
                w_load_misaligned = r_addr_lo[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_drop       = 1'b0;
        w_state_next = S_IDLE;
        if (r_state == S_WAIT_MEM) begin
            w_state_next = S_WAIT_MEM;
            if (memRspValid) begin
                w_drop       = w_load_misaligned;
                w_state_next = w_load_misaligned ? S_IDLE : S_WRITE;
            end
        end else if (w_accept) begin
            w_state_next = (inWbSel == 2'd1) ? S_WAIT_MEM : S_WRITE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rd         <= 5'd0;
            r_reg_write  <= 1'b0;
            r_data       <= '0;
            r_funct3     <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_misaligned <= w_drop;
            if (w_accept) begin
                r_rd        <= inRd;
                r_reg_write <= inRegWrite;
                r_funct3    <= inFunct3;
                r_addr_lo   <= inAluResult[1:0];
                if (inWbSel != 2'd1)
                    r_data <= (inWbSel == 2'd2) ? inPcPlus4 : inAluResult;
            end else if (r_state == S_WAIT_MEM && memRspValid && !w_load_misaligned) begin
                r_data <= w_load_data;
            end
        end
    end

    assign inReady        = (r_state != S_WAIT_MEM);
    assign loadPending    = (r_state == S_WAIT_MEM);
    assign loadMisaligned = r_misaligned;
    assign regWriteEnable = (r_state == S_WRITE) && r_reg_write && (r_rd != 5'd0);
    assign regWriteAddr   = r_rd;
    assign regWriteData   = r_data;
    assign fwdValid       = regWriteEnable;
    assign fwdRd          = r_rd;
    assign fwdData        = r_data;

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] r_instret;

    always_ff @(posedge clock) begin
        if (reset)
            r_instret <= 64'd0;
        else if (w_state_next == S_WRITE || w_drop)
            r_instret <= r_instret + 64'd1;
    end

    assign instret = r_instret;
`else
    assign instret = 64'h0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: expected regfile writes are queued at stimulus time
// and popped by a monitor whenever the DUT asserts regWriteEnable.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [4:0]  inRd = 5'd0;
    logic        inRegWrite = 1'b0;
    logic [1:0]  inWbSel = 2'd0;
    logic [2:0]  inFunct3 = 3'd0;
    logic [31:0] inAluResult = 32'd0;
    logic [31:0] inPcPlus4 = 32'd0;
    logic        memRspValid = 1'b0;
    logic [31:0] memRspData = 32'd0;
    logic        regWriteEnable;
    logic [4:0]  regWriteAddr;
    logic [31:0] regWriteData;
    logic        fwdValid;
    logic [4:0]  fwdRd;
    logic [31:0] fwdData;
    logic        loadPending;
    logic        loadMisaligned;
    logic [63:0] instret;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          passes = 0;
    int          writes_seen = 0;
    logic [63:0] exp_instret = 64'd0;

    writeback_stage #(.XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .inValid(inValid), .inReady(inReady),
        .inRd(inRd), .inRegWrite(inRegWrite), .inWbSel(inWbSel), .inFunct3(inFunct3),
        .inAluResult(inAluResult), .inPcPlus4(inPcPlus4),
        .memRspValid(memRspValid), .memRspData(memRspData),
        .regWriteEnable(regWriteEnable), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
        .fwdValid(fwdValid), .fwdRd(fwdRd), .fwdData(fwdData),
        .loadPending(loadPending), .loadMisaligned(loadMisaligned), .instret(instret)
    );

    always #5 clock = ~clock;

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clock) begin
        if (regWriteEnable) begin
            wr_t e;
            writes_seen++;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write: got x%0d=%h, required no write", regWriteAddr, regWriteData);
            end else begin
                e = sb.pop_front();
                if (regWriteAddr !== e.rd || regWriteData !== e.data || fwdValid !== 1'b1 ||
                    fwdRd !== e.rd || fwdData !== e.data)
                    $display("FAIL write: got x%0d=%h fwd(%b,x%0d=%h), required x%0d=%h",
                             regWriteAddr, regWriteData, fwdValid, fwdRd, fwdData, e.rd, e.data);
                else
                    passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_retire_check(input string name);
        logic [63:0] req;
`ifdef WB_RETIRE_COUNT_EN
        req = exp_instret;
`else
        req = 64'd0;
`endif
        checks++;
        if (instret !== req) $display("FAIL %s: instret got %0d, required %0d", name, instret, req);
        else passes++;
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] pc4);
        inValid = 1'b1; inRd = rd; inRegWrite = rw; inWbSel = sel;
        inFunct3 = 3'b010; inAluResult = alu; inPcPlus4 = pc4;
        if (rw && rd != 5'd0) sb.push_back({rd, (sel == 2'd2) ? pc4 : alu});
        exp_instret++;
        tick();
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_instret = 64'd0;
        #1;
        checks++;
        if (inReady !== 1'b1 || regWriteEnable !== 1'b0 || regWriteAddr !== 5'd0 ||
            regWriteData !== 32'd0 || fwdValid !== 1'b0 || fwdRd !== 5'd0 || fwdData !== 32'd0 ||
            loadPending !== 1'b0 || loadMisaligned !== 1'b0)
            $display("FAIL reset_outputs: rdy=%b we=%b a=%0d d=%h fv=%b lp=%b lm=%b, required rdy=1 rest 0",
                     inReady, regWriteEnable, regWriteAddr, regWriteData, fwdValid, loadPending, loadMisaligned);
        else passes++;
        exp_retire_check("reset_instret");
        $display("reset done");
    endtask

    task automatic test_alu();
        drive_op(5'd5, 1'b1, 2'd0, 32'hDEADBEEF, 32'h0);
        checks++;
        if (regWriteEnable !== 1'b1) $display("FAIL alu_latency: we got %b, required 1", regWriteEnable);
        else passes++;
        tick();
        checks++;
        if (regWriteEnable !== 1'b0) $display("FAIL alu_single: we got %b, required 0", regWriteEnable);
        else passes++;
        $display("alu x5=DEADBEEF issued");
    endtask

    task automatic test_back_to_back();
        int base;
        base = writes_seen;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (inReady !== 1'b1) $display("FAIL b2b_ready: got %b, required 1", inReady);
            else passes++;
            drive_op(i[4:0], 1'b1, 2'd0, 32'h1000_0000 + i, 32'h0);
            checks++;
            if (regWriteEnable !== 1'b1) $display("FAIL b2b_write%0d: we got %b, required 1", i, regWriteEnable);
            else passes++;
        end
        tick(); tick();
        checks++;
        if (writes_seen - base !== 3) $display("FAIL b2b_count: got %0d writes, required 3", writes_seen - base);
        else passes++;
        $display("back-to-back x1..x3 issued");
    endtask

    task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rsp, input int delay,
                           input logic mis, input logic [31:0] exp_data);
        inValid = 1'b1; inRd = rd; inRegWrite = 1'b1; inWbSel = 2'd1;
        inFunct3 = f3; inAluResult = addr; inPcPlus4 = 32'h0;
        tick();
        inValid = 1'b0;
        for (int c = 0; c < delay; c++) begin
            checks++;
            if (inReady !== 1'b0 || loadPending !== 1'b1)
                $display("FAIL %s_wait: rdy=%b lp=%b, required rdy=0 lp=1", name, inReady, loadPending);
            else passes++;
            tick();
        end
        memRspValid = 1'b1; memRspData = rsp;
        if (!mis && rd != 5'd0) sb.push_back({rd, exp_data});
        exp_instret++;
        tick();
        memRspValid = 1'b0;
        checks++;
        if (loadMisaligned !== mis || regWriteEnable !== (!mis && rd != 5'd0))
            $display("FAIL %s_rsp: lm=%b we=%b, required lm=%b we=%b", name, loadMisaligned,
                     regWriteEnable, mis, !mis);
        else passes++;
        tick();
        checks++;
        if (loadMisaligned !== 1'b0 || inReady !== 1'b1)
            $display("FAIL %s_after: lm=%b rdy=%b, required lm=0 rdy=1", name, loadMisaligned, inReady);
        else passes++;
        $display("load %s addr=%h rsp=%h", name, addr, rsp);
    endtask

    task automatic test_loads();
        do_load("lb",  5'd7,  3'b000, 32'h0000_1002, 32'h0080FF11, 3, 1'b0, 32'hFFFFFF80);
        do_load("lbu", 5'd8,  3'b100, 32'h0000_1002, 32'h0080FF11, 1, 1'b0, 32'h00000080);
        do_load("lh",  5'd9,  3'b001, 32'h0000_1000, 32'h12348001, 0, 1'b0, 32'hFFFF8001);
        do_load("lhu", 5'd10, 3'b101, 32'h0000_1002, 32'h8001ABCD, 2, 1'b0, 32'h00008001);
        do_load("lw",  5'd11, 3'b010, 32'h0000_1000, 32'h12345678, 1, 1'b0, 32'h12345678);
    endtask

    task automatic test_misaligned();
        do_load("lh_mis", 5'd12, 3'b001, 32'h0000_1003, 32'hCAFEBABE, 1, 1'b1, 32'h0);
        do_load("lw_mis", 5'd13, 3'b010, 32'h0000_1002, 32'hCAFEBABE, 0, 1'b1, 32'h0);
    endtask

    task automatic test_x0_and_jal();
        drive_op(5'd0, 1'b1, 2'd0, 32'h5555_AAAA, 32'h0);
        checks++;
        if (regWriteEnable !== 1'b0) $display("FAIL x0_write: we got %b, required 0", regWriteEnable);
        else passes++;
        drive_op(5'd1, 1'b1, 2'd2, 32'h0000_0BAD, 32'h0000_0104);
        tick();
        $display("x0 and jal issued");
    endtask

    task automatic test_reset_mid_load();
        inValid = 1'b1; inRd = 5'd14; inRegWrite = 1'b1; inWbSel = 2'd1;
        inFunct3 = 3'b010; inAluResult = 32'h0000_2000;
        tick();
        inValid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_instret = 64'd0;
        memRspValid = 1'b1; memRspData = 32'h7777_7777;
        tick();
        memRspValid = 1'b0;
        checks++;
        if (regWriteEnable !== 1'b0 || inReady !== 1'b1 || loadPending !== 1'b0)
            $display("FAIL reset_mid: we=%b rdy=%b lp=%b, required we=0 rdy=1 lp=0",
                     regWriteEnable, inReady, loadPending);
        else passes++;
        exp_retire_check("reset_mid_instret");
        for (int i = 1; i <= 3; i++) drive_op(i[4:0], 1'b1, 2'd0, 32'h2000_0000 + i, 32'h0);
        exp_retire_check("instret_three");
        tick();
        $display("reset during WAIT_MEM done");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_loads();
        test_misaligned();
        test_x0_and_jal();
        test_reset_mid_load();
        tick(); tick();
        checks++;
        if (sb.size() !== 0) $display("FAIL sb_drain: %0d writes outstanding, required 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
